// File: rtl/div_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_ctrl_if : bundle between the CPU execute stage, the divide sequencer
//               and the combinational divider.
//
// CPU side    : start, op_signed, op_a, op_b, mthi_we, mtlo_we, wdata (to
//               the sequencer); busy, done, div_zero, hi, lo (from it).
// Divider side: div_ena, div_sign, div_dividend, div_divisor (to divider);
//               div_q, div_r (from divider).
//
// modport slave  : the sequencer's view (div_ctrl).
// modport master : everything around it (CPU stage plus divider instance).
// ---------------------------------------------------------------------------
interface div_ctrl_if;
  logic        start;
  logic        op_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_ena;
  logic        div_sign;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_q;
  logic [31:0] div_r;

  modport slave (
    input  start, op_signed, op_a, op_b, mthi_we, mtlo_we, wdata,
    input  div_q, div_r,
    output busy, done, div_zero, hi, lo,
    output div_ena, div_sign, div_dividend, div_divisor
  );

  modport master (
    output start, op_signed, op_a, op_b, mthi_we, mtlo_we, wdata,
    output div_q, div_r,
    input  busy, done, div_zero, hi, lo,
    input  div_ena, div_sign, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl : multi-cycle sequencer for a combinational divider and the
//            HI/LO register pair (DIV, DIVU, MTHI, MTLO).
//
// Operands are latched on start and held on the divider inputs for LATENCY
// cycles, so the divider path can be constrained as a multicycle path.
// Quotient goes to LO, remainder to HI, then done pulses for one cycle.
// A zero divisor skips the divider and pulses done together with div_zero.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset
//   bus    div_ctrl_if.slave (CPU request/result and divider signals)
// Parameters:
//   LATENCY  cycles the divider inputs are held before capture (1..15)
//   CNT_W    width of the hold counter; must be able to hold LATENCY
// ---------------------------------------------------------------------------
module div_ctrl #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  div_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_next;
  logic [31:0]       r_hi,    w_hi_next;
  logic [31:0]       r_lo,    w_lo_next;
  logic [31:0]       r_a,     w_a_next;
  logic [31:0]       r_b,     w_b_next;
  logic              r_sign,  w_sign_next;
  logic              r_dz,    w_dz_next;
  logic              r_busy,  w_busy_next;
  logic              r_done,  w_done_next;

  // Next-state and datapath decisions.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_sign_next  = r_sign;
    w_dz_next    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          // start wins over any move in the same cycle
          if (bus.op_b != 32'd0) begin
            w_a_next     = bus.op_a;
            w_b_next     = bus.op_b;
            w_sign_next  = bus.op_signed;
            w_cnt_next   = CNT_LOAD;
            w_state_next = S_BUSY;
          end else begin
            // zero divisor: no divider access, HI/LO untouched
            w_dz_next    = 1'b1;
            w_state_next = S_DONE;
          end
        end else begin
          if (bus.mthi_we) w_hi_next = bus.wdata;
          if (bus.mtlo_we) w_lo_next = bus.wdata;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          // inputs have now been stable for LATENCY cycles
          w_lo_next    = bus.div_q;
          w_hi_next    = bus.div_r;
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of the upcoming state.
    w_busy_next = (w_state_next == S_BUSY);
    w_done_next = (w_state_next == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sign  <= 1'b0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_sign  <= w_sign_next;
      r_dz    <= w_dz_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.div_zero     = r_dz;
  assign bus.hi           = r_hi;
  assign bus.lo           = r_lo;
  assign bus.div_ena      = r_busy;
  assign bus.div_sign     = r_sign;
  assign bus.div_dividend = r_a;
  assign bus.div_divisor  = r_b;

endmodule

// File: tb/tb_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_ctrl : directed bench for div_ctrl with a scoreboard.
// Each issued divide pushes its expected HI/LO/div_zero and done cycle into a
// queue; a monitor pops and compares on every done pulse. A behavioural
// divider returns junk until its inputs have been held stable long enough.
// ---------------------------------------------------------------------------
module tb_div_ctrl;
  localparam int L = 4;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;

  div_ctrl_if bus ();

  div_ctrl #(.LATENCY(L), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural divider with multicycle check -------------
  logic [31:0] prev_a, prev_b;
  logic        prev_s, prev_ena;
  int          stable;

  always @(posedge clk) begin
    if (!bus.div_ena) begin
      stable <= 0;
    end else if (prev_ena) begin
      chk("div_inputs_held",
          {31'd0, (bus.div_dividend != prev_a) || (bus.div_divisor != prev_b) ||
                  (bus.div_sign != prev_s)}, 32'd0);
      stable <= stable + 1;
    end else begin
      stable <= 1;
    end
    prev_a   <= bus.div_dividend;
    prev_b   <= bus.div_divisor;
    prev_s   <= bus.div_sign;
    prev_ena <= bus.div_ena;
  end

  always_comb begin
    bus.div_q = 32'hBAD0_BAD0;
    bus.div_r = 32'h0BAD_0BAD;
    if (bus.div_ena && stable >= L - 1 && bus.div_divisor != 32'd0) begin
      if (bus.div_sign) begin
        bus.div_q = $unsigned($signed(bus.div_dividend) / $signed(bus.div_divisor));
        bus.div_r = $unsigned($signed(bus.div_dividend) % $signed(bus.div_divisor));
      end else begin
        bus.div_q = bus.div_dividend / bus.div_divisor;
        bus.div_r = bus.div_dividend % bus.div_divisor;
      end
    end
  end

  // ---------------- monitor ------------------------------------------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.div_zero && !bus.done) chk("dz_without_done", 32'd1, 32'd0);
      if (bus.done) begin
        $display("done  cycle=%0d hi=%h lo=%h div_zero=%0d", cyc, bus.hi, bus.lo, bus.div_zero);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("hi", bus.hi, e.hi);
          chk("lo", bus.lo, e.lo);
          chk("div_zero", {31'd0, bus.div_zero}, {31'd0, e.dz});
        end
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic push);
    exp_t e;
    bus.start     = 1'b1;
    bus.op_signed = s;
    bus.op_a      = a;
    bus.op_b      = b;
    e.hi  = eh;
    e.lo  = el;
    e.dz  = (b == 32'd0);
    e.cyc = (b == 32'd0) ? cyc + 1 : cyc + L + 1;
    if (push) sb.push_back(e);
    $display("issue cycle=%0d signed=%0d a=%h b=%h", cyc, s, a, b);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic move(input logic whi, input logic wlo, input logic [31:0] d);
    bus.mthi_we = whi;
    bus.mtlo_we = wlo;
    bus.wdata   = d;
    $display("move  cycle=%0d hi_we=%0d lo_we=%0d data=%h", cyc, whi, wlo, d);
    @(posedge clk); #1;
    bus.mthi_we = 1'b0;
    bus.mtlo_we = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.op_signed = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.mthi_we  = 1'b0;
    bus.mtlo_we  = 1'b0;
    bus.wdata    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
    chk("rst_div_ena", {31'd0, bus.div_ena}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_dividend", bus.div_dividend, 32'd0);
    chk("rst_divisor", bus.div_divisor, 32'd0);
    @(posedge clk); #1;

    // signed -7 / 2: busy and held inputs in cycles 1..L
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      chk("sgn_busy", {31'd0, bus.busy}, 32'd1);
      chk("sgn_ena", {31'd0, bus.div_ena}, 32'd1);
      chk("sgn_dividend", bus.div_dividend, 32'hFFFF_FFF9);
      chk("sgn_sign", {31'd0, bus.div_sign}, 32'd1);
    end
    wait_done();
    chk("sgn_busy_after", {31'd0, bus.busy}, 32'd0);

    // unsigned 100 / 7
    issue(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    wait_done();

    // MTHI/MTLO presets, including both in one cycle
    move(1'b1, 1'b1, 32'hA5A5_A5A5);
    @(negedge clk);
    chk("mv_both_hi", bus.hi, 32'hA5A5_A5A5);
    chk("mv_both_lo", bus.lo, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    move(1'b1, 1'b0, 32'h1111_1111);
    move(1'b0, 1'b1, 32'h2222_2222);
    @(negedge clk);
    chk("mthi", bus.hi, 32'h1111_1111);
    chk("mtlo", bus.lo, 32'h2222_2222);
    @(posedge clk); #1;

    // divide by zero: done+div_zero in cycle 1, HI/LO unchanged
    issue(1'b1, 32'd55, 32'd0, 32'h1111_1111, 32'h2222_2222, 1'b1);
    @(negedge clk);
    chk("dz_done", {31'd0, bus.done}, 32'd1);
    chk("dz_busy", {31'd0, bus.busy}, 32'd0);
    chk("dz_ena", {31'd0, bus.div_ena}, 32'd0);
    @(negedge clk);
    chk("dz_done_once", {31'd0, bus.done}, 32'd0);
    chk("dz_busy2", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;

    // conflicts: start + mthi_we, then mtlo_we and a second start in BUSY
    bus.mthi_we = 1'b1;
    bus.wdata   = 32'hDEAD_BEEF;
    issue(1'b0, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b1);
    bus.mthi_we = 1'b0;
    @(negedge clk);
    chk("cf_hi_not_moved", bus.hi, 32'h1111_1111);
    @(posedge clk); #1;
    bus.mtlo_we   = 1'b1;
    bus.wdata     = 32'h5555_AAAA;
    bus.start     = 1'b1;
    bus.op_a      = 32'd7;
    bus.op_b      = 32'd0;
    @(posedge clk); #1;
    bus.mtlo_we = 1'b0;
    bus.start   = 1'b0;
    @(negedge clk);
    chk("cf_lo_not_moved", bus.lo, 32'h2222_2222);
    chk("cf_dividend_held", bus.div_dividend, 32'd1000);
    wait_done();
    repeat (6) @(posedge clk);
    #1;

    // reset in cycle 2 of BUSY abandons the divide
    issue(1'b0, 32'd500, 32'd9, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
    chk("mid_rst_ena", {31'd0, bus.div_ena}, 32'd0);
    chk("mid_rst_hi", bus.hi, 32'd0);
    chk("mid_rst_lo", bus.lo, 32'd0);
    repeat (6) @(posedge clk);
    #1;

    // fresh divide after reset: 50 / 6
    issue(1'b0, 32'd50, 32'd6, 32'd2, 32'd8, 1'b1);
    wait_done();
    repeat (4) @(posedge clk);
    #1;

    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle sequencer that owns the combinational divider and the HI/LO register pair for DIV/DIVU/MTHI/MTLO.
- Latches operands and holds them stable on the divider inputs for LATENCY cycles, so the long divider path is a declared multicycle path.
- Captures quotient into LO and remainder into HI, then pulses done.
- Sits between the CPU decode/execute stage, which stalls on start|busy, and a div instance.

Parameters:
- LATENCY, 4, cycles the divider inputs are held before capture; legal range 1..15.
- CNT_W, 4, width of the internal cycle counter; must hold LATENCY.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a divide; sampled only in IDLE.
- op_signed  in  1  1 = DIV (signed), 0 = DIVU.
- op_a  in  32  dividend.
- op_b  in  32  divisor.
- mthi_we  in  1  write wdata to HI; honoured only in IDLE without start.
- mtlo_we  in  1  write wdata to LO; same rule as mthi_we.
- wdata  in  32  MTHI/MTLO data.
- busy  out  1  registered; high while the divide is in flight.
- done  out  1  one-cycle pulse after HI/LO are updated or divide-by-zero is flagged.
- div_zero  out  1  one-cycle pulse coincident with done when op_b was 0.
- hi  out  32  HI register (remainder).
- lo  out  32  LO register (quotient).
- div_ena  out  1  enable to the divider; high only in BUSY.
- div_sign  out  1  latched op_signed, driven to the divider.
- div_dividend  out  32  latched op_a.
- div_divisor  out  32  latched op_b.
- div_q  in  32  divider quotient.
- div_r  in  32  divider remainder.

Behaviour:
- Clocking: single clock; every register updates on the rising edge of clk.
- Reset (synchronous, active-high, overrides everything):
  - state = IDLE, counter = 0.
  - hi = lo = 0, busy = done = div_zero = div_ena = 0.
  - Latched operands = 0, div_sign = 0.
  - Reset asserted mid-divide abandons the operation: no capture, no done pulse.
- States: IDLE, BUSY, DONE.
- IDLE, start=1, op_b≠0:
  - Latch op_a, op_b, op_signed.
  - Counter = LATENCY-1; go to BUSY.
- IDLE, start=1, op_b=0:
  - No divider access; HI/LO unchanged.
  - Go to DONE with div_zero set.
- IDLE, start=0:
  - mthi_we loads hi <= wdata; mtlo_we loads lo <= wdata.
  - Both may be asserted in the same cycle.
- BUSY:
  - div_ena = 1; operands held constant.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: lo <= div_q, hi <= div_r; go to DONE.
- DONE:
  - done = 1 for exactly one cycle (plus div_zero if flagged); then IDLE.
  - start in DONE is ignored; the CPU re-issues after done.
- Timing: with start sampled at edge 0:
  - busy is high for cycles 1..LATENCY.
  - Capture occurs at edge LATENCY.
  - done is high in cycle LATENCY+1.
  - Total = LATENCY+1 cycles from start to done.
  - Divide-by-zero: done and div_zero are high in cycle 1.
- Priority and conflicts:
  - start beats mthi_we/mtlo_we in the same IDLE cycle; the moves are dropped.
  - start, mthi_we and mtlo_we in BUSY or DONE are ignored; HI/LO change only at capture.
- hi/lo are stable outputs outside capture and move cycles, so mfhi/mflo can read them directly when busy=0.
- div_dividend, div_divisor and div_sign remain at their last latched values in IDLE; div_ena=0 marks them don't-care to the divider.
- Results are taken verbatim from the divider; the controller does no sign fix-up.

Test Plan:
- Bench uses a behavioural divider model with a LATENCY-cycle multicycle check on its inputs.
- Signed divide, LATENCY=4: start, op_signed=1, op_a=0xFFFFFFF9 (-7), op_b=2 -> busy in cycles 1-4, div_ena=1, inputs constant; done in cycle 5; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Unsigned divide: op_signed=0, op_a=100, op_b=7 -> lo=14, hi=2 at done; div_zero=0.
- Divide by zero: hi=0x11111111, lo=0x22222222 preset via MTHI/MTLO; start with op_b=0 -> done=div_zero=1 in cycle 1; busy and div_ena never high; hi/lo unchanged.
- Conflicts: start with mthi_we=1, wdata=0xDEADBEEF in IDLE -> divide runs, HI not written by the move. mtlo_we pulsed in BUSY -> ignored; final lo=quotient. A second start in BUSY -> ignored, exactly one done pulse.
- Reset mid-op: reset in cycle 2 of BUSY -> next cycle state IDLE, busy=done=div_ena=0, hi=lo=0. A new start afterwards completes normally in LATENCY+1 cycles.
